// File: rtl/punc_control_pkg.sv
// Shared definitions for the PUnC LC3 control unit and datapath: FSM state
// encoding, opcodes, branch-condition bit indices, datapath select encodings
// and the packed control-strobe bundle.
package punc_control_pkg;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_DECODE,
      ST_EXECUTE,
      ST_EXECUTE2,
      ST_HALT
   } state_t;

   localparam logic [3:0] OP_BR   = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_LD   = 4'b0010;
   localparam logic [3:0] OP_ST   = 4'b0011;
   localparam logic [3:0] OP_JSR  = 4'b0100;
   localparam logic [3:0] OP_AND  = 4'b0101;
   localparam logic [3:0] OP_LDR  = 4'b0110;
   localparam logic [3:0] OP_STR  = 4'b0111;
   localparam logic [3:0] OP_RTI  = 4'b1000;
   localparam logic [3:0] OP_NOT  = 4'b1001;
   localparam logic [3:0] OP_LDI  = 4'b1010;
   localparam logic [3:0] OP_STI  = 4'b1011;
   localparam logic [3:0] OP_JMP  = 4'b1100;
   localparam logic [3:0] OP_RSV  = 4'b1101;
   localparam logic [3:0] OP_LEA  = 4'b1110;
   localparam logic [3:0] OP_TRAP = 4'b1111;

   localparam int BR_N = 11;
   localparam int BR_Z = 10;
   localparam int BR_P = 9;

   localparam logic [1:0] PC_SEL_OFF9   = 2'b00;
   localparam logic [1:0] PC_SEL_OFF11  = 2'b01;
   localparam logic [1:0] PC_SEL_RQ     = 2'b10;

   localparam logic [1:0] RADDR_PC      = 2'b00;
   localparam logic [1:0] RADDR_OFF9    = 2'b01;
   localparam logic [1:0] RADDR_TEMP    = 2'b10;
   localparam logic [1:0] RADDR_RQ_OFF6 = 2'b11;

   localparam logic [1:0] WADDR_OFF9    = 2'b00;
   localparam logic [1:0] WADDR_RQ_OFF6 = 2'b01;
   localparam logic [1:0] WADDR_TEMP    = 2'b10;

   localparam logic [1:0] WDATA_ALU     = 2'b00;
   localparam logic [1:0] WDATA_MEM     = 2'b01;
   localparam logic [1:0] WDATA_PC      = 2'b10;
   localparam logic [1:0] WDATA_OFF9    = 2'b11;

   localparam logic       WREG_IR       = 1'b0;
   localparam logic       WREG_R7       = 1'b1;

   localparam logic       RP_IR11       = 1'b0;
   localparam logic       RP_IR2        = 1'b1;

   localparam logic [1:0] ALU_ADD       = 2'b00;
   localparam logic [1:0] ALU_AND       = 2'b01;
   localparam logic [1:0] ALU_NOT       = 2'b10;
   localparam logic [1:0] ALU_PASS_A    = 2'b11;

   localparam logic       ALU_A_RP      = 1'b0;
   localparam logic       ALU_A_IMM     = 1'b1;

   typedef struct packed {
      logic       pc_ld;
      logic       pc_clr;
      logic       pc_inc;
      logic [1:0] pc_sel;
      logic       ir_ld;
      logic       ir_clr;
      logic       dmem_rd;
      logic       dmem_wr;
      logic [1:0] dmem_r_addr_sel;
      logic [1:0] dmem_w_addr_sel;
      logic [1:0] rf_w_data_sel;
      logic       rf_w_addr_sel;
      logic       rf_w_wr;
      logic       rf_rp_addr_sel;
      logic       rf_rp_rd;
      logic       rf_rq_rd;
      logic       temp_ld;
      logic       nzp_ld;
      logic       nzp_clr;
      logic [1:0] alu_sel;
      logic       alu_in_a_sel;
      logic       halted;
   } ctrl_t;

   // Opcodes that stop the machine instead of executing.
   function automatic logic is_halt_op(input logic [3:0] op);
      return (op == OP_TRAP) || (op == OP_RTI) || (op == OP_RSV);
   endfunction

   // Opcodes that need the second, indirect execute cycle.
   function automatic logic is_indirect(input logic [3:0] op);
      return (op == OP_LDI) || (op == OP_STI);
   endfunction

endpackage

// File: rtl/punc_control_decode.sv
// Combinational map from FSM state and instruction fields to the full set
// of datapath control strobes. Everything not explicitly driven stays 0.
module punc_control_decode
   import punc_control_pkg::*;
(
   input  state_t     state,
   input  logic [3:0] opcode,
   input  logic       ir_bit11,
   input  logic       ir_bit5,
   input  logic       nzp_match,
   output ctrl_t      ctrl
);

   // Moore decode of the strobe bundle for the current state and opcode
   always_comb begin
      ctrl = '0;
      case (state)
         ST_FETCH: begin
            ctrl.dmem_rd         = 1'b1;
            ctrl.dmem_r_addr_sel = RADDR_PC;
            ctrl.ir_ld           = 1'b1;
            ctrl.pc_inc          = 1'b1;
         end
         ST_EXECUTE: begin
            case (opcode)
               OP_ADD, OP_AND: begin
                  ctrl.alu_sel        = (opcode == OP_AND) ? ALU_AND : ALU_ADD;
                  ctrl.alu_in_a_sel   = ir_bit5 ? ALU_A_IMM : ALU_A_RP;
                  ctrl.rf_rp_addr_sel = RP_IR2;
                  ctrl.rf_rp_rd       = ~ir_bit5;
                  ctrl.rf_rq_rd       = 1'b1;
                  ctrl.rf_w_wr        = 1'b1;
                  ctrl.nzp_ld         = 1'b1;
               end
               OP_NOT: begin
                  ctrl.alu_sel  = ALU_NOT;
                  ctrl.rf_rq_rd = 1'b1;
                  ctrl.rf_w_wr  = 1'b1;
                  ctrl.nzp_ld   = 1'b1;
               end
               OP_LD, OP_LDR: begin
                  ctrl.dmem_r_addr_sel = (opcode == OP_LDR) ? RADDR_RQ_OFF6 : RADDR_OFF9;
                  ctrl.rf_rq_rd        = (opcode == OP_LDR);
                  ctrl.rf_w_data_sel   = WDATA_MEM;
                  ctrl.rf_w_wr         = 1'b1;
                  ctrl.nzp_ld          = 1'b1;
               end
               OP_LEA: begin
                  ctrl.rf_w_data_sel = WDATA_OFF9;
                  ctrl.rf_w_wr       = 1'b1;
                  ctrl.nzp_ld        = 1'b1;
               end
               OP_ST, OP_STR: begin
                  ctrl.dmem_wr         = 1'b1;
                  ctrl.dmem_w_addr_sel = (opcode == OP_STR) ? WADDR_RQ_OFF6 : WADDR_OFF9;
                  ctrl.rf_rp_addr_sel  = RP_IR11;
                  ctrl.rf_rp_rd        = 1'b1;
                  ctrl.rf_rq_rd        = (opcode == OP_STR);
               end
               OP_BR: begin
                  ctrl.pc_sel = PC_SEL_OFF9;
                  ctrl.pc_ld  = nzp_match;
               end
               OP_JMP: begin
                  ctrl.pc_sel   = PC_SEL_RQ;
                  ctrl.pc_ld    = 1'b1;
                  ctrl.rf_rq_rd = 1'b1;
               end
               OP_JSR: begin
                  ctrl.pc_sel        = ir_bit11 ? PC_SEL_OFF11 : PC_SEL_RQ;
                  ctrl.rf_rq_rd      = ~ir_bit11;
                  ctrl.pc_ld         = 1'b1;
                  ctrl.rf_w_addr_sel = WREG_R7;
                  ctrl.rf_w_data_sel = WDATA_PC;
                  ctrl.rf_w_wr       = 1'b1;
               end
               OP_LDI, OP_STI: begin
                  ctrl.dmem_r_addr_sel = RADDR_OFF9;
                  ctrl.temp_ld         = 1'b1;
               end
               default: ctrl = '0;
            endcase
         end
         ST_EXECUTE2: begin
            if (opcode == OP_LDI) begin
               ctrl.dmem_r_addr_sel = RADDR_TEMP;
               ctrl.rf_w_data_sel   = WDATA_MEM;
               ctrl.rf_w_wr         = 1'b1;
               ctrl.nzp_ld          = 1'b1;
            end else if (opcode == OP_STI) begin
               ctrl.dmem_wr         = 1'b1;
               ctrl.dmem_w_addr_sel = WADDR_TEMP;
               ctrl.rf_rp_addr_sel  = RP_IR11;
               ctrl.rf_rp_rd        = 1'b1;
            end
         end
         ST_HALT: ctrl.halted = 1'b1;
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/punc_control.sv
// PUnC LC3 control unit: fetch/decode/execute FSM driving the datapath.
// Optional retired-instruction counter enabled by PUNC_INSTR_COUNT_EN.
module punc_control
   import punc_control_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] ir_out,
   input  logic        nzp_match,
   output logic        pc_ld,
   output logic        pc_clr,
   output logic        pc_inc,
   output logic [1:0]  pc_sel,
   output logic        ir_ld,
   output logic        ir_clr,
   output logic        dmem_rd,
   output logic        dmem_wr,
   output logic [1:0]  dmem_r_addr_sel,
   output logic [1:0]  dmem_w_addr_sel,
   output logic [1:0]  rf_w_data_sel,
   output logic        rf_w_addr_sel,
   output logic        rf_w_wr,
   output logic        rf_rp_addr_sel,
   output logic        rf_rp_rd,
   output logic        rf_rq_rd,
   output logic        temp_ld,
   output logic        nzp_ld,
   output logic        nzp_clr,
   output logic [1:0]  alu_sel,
   output logic        alu_in_a_sel,
   output logic        halted
`ifdef PUNC_INSTR_COUNT_EN
   ,output logic [15:0] instr_count
`endif
);

   state_t     state;
   state_t     next_state;
   ctrl_t      dec_ctrl;
   ctrl_t      ctrl;
   logic [3:0] opcode;
   logic       unused_ir;

   assign opcode    = ir_out[15:12];
   assign unused_ir = ^{ir_out[10:6], ir_out[4:0]};

   punc_control_decode u_decode (
      .state     (state),
      .opcode    (opcode),
      .ir_bit11  (ir_out[11]),
      .ir_bit5   (ir_out[5]),
      .nzp_match (nzp_match),
      .ctrl      (dec_ctrl)
   );

   // State register; reset always restarts at FETCH, which also leaves HALT
   always_ff @(posedge clk) begin
      if (rst) state <= ST_FETCH;
      else     state <= next_state;
   end

   // Sequencing: one execute cycle, two for the indirect memory opcodes
   always_comb begin
      next_state = state;
      case (state)
         ST_FETCH:    next_state = ST_DECODE;
         ST_DECODE:   next_state = is_halt_op(opcode) ? ST_HALT : ST_EXECUTE;
         ST_EXECUTE:  next_state = is_indirect(opcode) ? ST_EXECUTE2 : ST_FETCH;
         ST_EXECUTE2: next_state = ST_FETCH;
         ST_HALT:     next_state = ST_HALT;
         default:     next_state = ST_FETCH;
      endcase
   end

   // Reset overrides the decoded strobes so an in-flight instruction commits nothing
   always_comb begin
      ctrl = dec_ctrl;
      if (rst) begin
         ctrl         = '0;
         ctrl.pc_clr  = 1'b1;
         ctrl.ir_clr  = 1'b1;
         ctrl.nzp_clr = 1'b1;
      end
   end

   assign pc_ld           = ctrl.pc_ld;
   assign pc_clr          = ctrl.pc_clr;
   assign pc_inc          = ctrl.pc_inc;
   assign pc_sel          = ctrl.pc_sel;
   assign ir_ld           = ctrl.ir_ld;
   assign ir_clr          = ctrl.ir_clr;
   assign dmem_rd         = ctrl.dmem_rd;
   assign dmem_wr         = ctrl.dmem_wr;
   assign dmem_r_addr_sel = ctrl.dmem_r_addr_sel;
   assign dmem_w_addr_sel = ctrl.dmem_w_addr_sel;
   assign rf_w_data_sel   = ctrl.rf_w_data_sel;
   assign rf_w_addr_sel   = ctrl.rf_w_addr_sel;
   assign rf_w_wr         = ctrl.rf_w_wr;
   assign rf_rp_addr_sel  = ctrl.rf_rp_addr_sel;
   assign rf_rp_rd        = ctrl.rf_rp_rd;
   assign rf_rq_rd        = ctrl.rf_rq_rd;
   assign temp_ld         = ctrl.temp_ld;
   assign nzp_ld          = ctrl.nzp_ld;
   assign nzp_clr         = ctrl.nzp_clr;
   assign alu_sel         = ctrl.alu_sel;
   assign alu_in_a_sel    = ctrl.alu_in_a_sel;
   assign halted          = ctrl.halted;

`ifdef PUNC_INSTR_COUNT_EN
   logic retire;

   assign retire = ((state == ST_EXECUTE) && !is_indirect(opcode)) || (state == ST_EXECUTE2);

   // Count instructions on their last execute cycle; wraps at 16 bits
   always_ff @(posedge clk) begin
      if (rst)         instr_count <= '0;
      else if (retire) instr_count <= instr_count + 16'd1;
   end
`endif

endmodule

// File: doc/punc_control.md
# punc_control

Control unit for the PUnC LC3 processor. It sequences every instruction through fetch, decode and execute. It consumes `ir_out` and `nzp_match` from the datapath and drives all datapath load, clear, select and enable strobes. It is a Moore-style FSM with one opcode-dependent execute stage, plus a second execute stage for the indirect memory instructions (LDI, STI).

## Interface
- Parameters: none.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ir_out`  in  16  current instruction register from the datapath.
- `nzp_match`  in  1  branch condition result from the datapath.
- `pc_ld`, `pc_clr`, `pc_inc`  out  1 each  PC controls.
- `pc_sel`  out  2  PC load source: 00 PC+sext(ir[8:0]), 01 PC+sext(ir[10:0]), 10 rf_rq_data.
- `ir_ld`, `ir_clr`  out  1 each  IR controls.
- `dmem_rd`, `dmem_wr`  out  1 each  memory strobes.
- `dmem_r_addr_sel`  out  2  read address: 00 PC, 01 PC+sext(ir[8:0]), 10 temp, 11 rq+sext(ir[5:0]).
- `dmem_w_addr_sel`  out  2  write address: 00 PC+sext(ir[8:0]), 01 rq+sext(ir[5:0]), 10 temp.
- `rf_w_data_sel`  out  2  write data: 00 ALU, 01 dmem_r_data, 10 PC, 11 PC+sext(ir[8:0]).
- `rf_w_addr_sel`  out  1  write address: 0 ir[11:9], 1 R7.
- `rf_w_wr`  out  1  register file write enable.
- `rf_rp_addr_sel`  out  1  rp read address: 0 ir[11:9], 1 ir[2:0].
- `rf_rp_rd`, `rf_rq_rd`  out  1 each  read enables.
- `temp_ld`  out  1  loads temp from dmem_r_data.
- `nzp_ld`, `nzp_clr`  out  1 each  condition-code controls.
- `alu_sel`  out  2  ALU operation: 00 ADD, 01 AND, 10 NOT, 11 PASS_A.
- `alu_in_a_sel`  out  1  second ALU operand: 0 rf_rp_data, 1 sext(ir[4:0]).
- `halted`  out  1  high in HALT state.
- `instr_count`  out  16  retired-instruction count; present only with PUNC_INSTR_COUNT_EN.

## Operation
- States: FETCH, DECODE, EXECUTE, EXECUTE2, HALT. All outputs decode from the state and `ir_out`. Every output defaults to 0.
- FETCH: `dmem_rd`=1, `dmem_r_addr_sel`=00, `ir_ld`=1, `pc_inc`=1. Transitions to DECODE.
- DECODE: all strobes 0. Transitions to EXECUTE, or to HALT for opcodes 1111 (TRAP), 1000 (RTI) and 1101 (reserved).
- EXECUTE, by opcode in `ir_out[15:12]`:
  - ADD/AND: `alu_sel` set per opcode; `alu_in_a_sel`=ir[5]; `rf_rp_addr_sel`=1; `rf_w_wr`=1; `nzp_ld`=1.
  - NOT: `alu_sel`=10; `rf_w_wr`=1; `nzp_ld`=1.
  - LD: `dmem_r_addr_sel`=01; `rf_w_data_sel`=01; `rf_w_wr`=1; `nzp_ld`=1.
  - LDR: same as LD except `dmem_r_addr_sel`=11.
  - LEA: `rf_w_data_sel`=11; `rf_w_wr`=1; `nzp_ld`=1.
  - ST: `dmem_wr`=1; `dmem_w_addr_sel`=00; `rf_rp_addr_sel`=0.
  - STR: same as ST except `dmem_w_addr_sel`=01.
  - BR: `pc_sel`=00; `pc_ld`=`nzp_match`.
  - JMP/RET: `pc_sel`=10; `pc_ld`=1.
  - JSR (ir[11]=1): `pc_sel`=01. JSRR (ir[11]=0): `pc_sel`=10. Both: `pc_ld`=1, `rf_w_addr_sel`=1, `rf_w_data_sel`=10, `rf_w_wr`=1. The R7 write and the PC load commit on the same edge and both sample the pre-edge PC and rq, so JSRR R7 is correct.
  - LDI/STI: `dmem_r_addr_sel`=01; `temp_ld`=1. Transitions to EXECUTE2.
  - All other opcodes in EXECUTE transition to FETCH.
- EXECUTE2, then FETCH:
  - LDI: `dmem_r_addr_sel`=10; `rf_w_data_sel`=01; `rf_w_wr`=1; `nzp_ld`=1.
  - STI: `dmem_wr`=1; `dmem_w_addr_sel`=10.
- HALT: all strobes 0; `halted`=1. Exits only on `rst`.
- `rf_rp_rd` and `rf_rq_rd` are 1 in any state that uses the respective read port.

## Timing
- Memory reads are asynchronous; memory, register file, PC and IR writes are synchronous.
- Latency: 3 cycles per instruction, 4 cycles for LDI and STI.
- While `rst`=1, outputs are `pc_clr`=`ir_clr`=`nzp_clr`=1 and all other outputs 0. The next state is FETCH. `instr_count` resets to 0.
- Reset asserted mid-instruction aborts it: no `dmem_wr`, `rf_w_wr` or `pc_ld` is issued in the reset cycle.
- Reset values after release: state FETCH, `halted`=0.

## Configuration
- PUNC_INSTR_COUNT_EN defined: adds the `instr_count` port.
  - Increments on the final execute cycle of each retired instruction.
  - Wraps from 0xFFFF to 0x0000.
  - HALT and TRAP are not counted.
- Undefined: the port and the counter are absent; control behaviour is unchanged.

## Structure
- Shared package (Defines): state encoding, opcode constants, BR_N/BR_Z/BR_P bit indices, and all select encodings listed above. The datapath uses the same package.
- One sub-module: `punc_control_decode`, a combinational map from (state, opcode, ir bits, `nzp_match`) to the control output bundle. The top level holds the state register, the next-state logic and the optional counter.

## Test plan
- Reset, then ADD R1,R2,#3 (0x12A3): FETCH, DECODE, EXECUTE. In EXECUTE: `alu_sel`=00, `alu_in_a_sel`=1, `rf_w_wr`=1, `nzp_ld`=1. `instr_count`=1.
- BRz #4 (0x0404) with `nzp_match`=1 gives `pc_ld`=1, `pc_sel`=00. Repeated with `nzp_match`=0 gives `pc_ld`=0.
- LDI R0,#2 (0xA002):
  - EXECUTE: `temp_ld`=1, `dmem_r_addr_sel`=01.
  - EXECUTE2: `dmem_r_addr_sel`=10, `rf_w_data_sel`=01, `rf_w_wr`=1.
  - Next FETCH occurs 4 cycles after the first.
- JSR #-1 (0x4FFF): in EXECUTE, `pc_ld`=1, `pc_sel`=01, `rf_w_addr_sel`=1, `rf_w_data_sel`=10, `rf_w_wr`=1.
- TRAP (0xF025): `halted`=1 from the cycle after DECODE, and no `ir_ld` for 10 further cycles. `rst` then returns the FSM to FETCH with `halted`=0.
- `rst` in the EXECUTE cycle of STR (0x7240): `dmem_wr`=0 that cycle, next state FETCH, and `pc_clr`=1 while `rst` is high.
